// File: rtl/key_schedule_ctrl.sv
// key_schedule_ctrl: AES-128 round-key sequencer.
// One combinational expansion step is shared between the decrypt precompute
// (forward walk up to the last round key) and the stream phase (forward or
// inverse stepping, one key per handshake).
// Optional macro LAST_KEY_CACHE_EN: remember the cipher key and its final
// round key so that a repeated reverse start can skip the precompute walk.
module key_schedule_ctrl #(
  parameter int unsigned NUM_ROUNDS = 10
) (
  input  logic         i_Clk,
  input  logic         i_Rst,
  input  logic         i_Start,
  input  logic         i_fEncrypt,
  input  logic [127:0] i_Key,
  input  logic         i_Ready,
  output logic         o_Busy,
  output logic         o_Valid,
  output logic [127:0] o_RoundKey,
  output logic [3:0]   o_RoundNum,
  output logic         o_Last
);

  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

  // AES S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    IDLE,
    PRECOMP,
    STREAM
  } state_t;

  state_t state, state_next;

  logic [127:0] key_reg, key_d;
  logic [3:0]   round, round_d;
  logic [3:0]   step_cnt, step_d;
  logic         dir, dir_d;
  logic [127:0] out_key;
  logic [3:0]   out_num;

  logic         at_last;
  logic         cache_hit;
  logic [127:0] hit_key;

  logic [3:0]   step_round;
  logic         step_dir;
  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  core_word, temp_word;
  logic [31:0]  n0, n1, n2, n3;
  logic [127:0] step_out;

  function automatic logic [7:0] sub_byte(input logic [7:0] x);
    return SBOX_TBL[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
    return {sub_byte(w[23:16]), sub_byte(w[15:8]), sub_byte(w[7:0]), sub_byte(w[31:24])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] rc;
    unique case (r)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  // Stream-end detect: final key of the stream is being presented.
  always_comb begin
    at_last = 1'b0;
    if (state == STREAM) begin
      at_last = dir ? (round == LAST_RND) : (round == '0);
    end
  end

  // Step control: precompute always walks forward using the step counter;
  // the stream bridges round -> round+1 (forward) or round -> round-1 (inverse),
  // and the step's round input is always the higher index of that pair.
  always_comb begin
    step_round = step_cnt;
    step_dir   = 1'b1;
    if (state == STREAM) begin
      step_dir   = dir;
      step_round = dir ? (round + 4'd1) : round;
    end
  end

  // Single key-expansion step (forward or inverse) applied to key_reg.
  // The inverse recovers w3 first so the same SubWord/RotWord path serves both.
  always_comb begin
    w0 = key_reg[127:96];
    w1 = key_reg[95:64];
    w2 = key_reg[63:32];
    w3 = key_reg[31:0];
    core_word = step_dir ? w3 : (w3 ^ w2);
    temp_word = sub_rot_word(core_word) ^ {rcon(step_round), 24'h000000};
    n0 = w0 ^ temp_word;
    if (step_dir) begin
      n1 = w1 ^ n0;
      n2 = w2 ^ n1;
      n3 = w3 ^ n2;
    end else begin
      n1 = w1 ^ w0;
      n2 = w2 ^ w1;
      n3 = w3 ^ w2;
    end
    step_out = {n0, n1, n2, n3};
  end

`ifdef LAST_KEY_CACHE_EN
  logic [127:0] cipher_key;
  logic [127:0] cache_key;
  logic [127:0] cache_last;
  logic         cache_valid;
  logic         reach_last;

  // Cache lookup and the "round NUM_ROUNDS just reached" strobe.
  always_comb begin
    cache_hit  = cache_valid && (cache_key == i_Key);
    hit_key    = cache_last;
    reach_last = ((state == PRECOMP) && (step_cnt == LAST_RND)) ||
                 ((state == STREAM) && dir && i_Ready && !at_last &&
                  ((round + 4'd1) == LAST_RND));
  end

  // Cache storage: remember the cipher key of the run and its final round key.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      cipher_key  <= '0;
      cache_key   <= '0;
      cache_last  <= '0;
      cache_valid <= 1'b0;
    end else begin
      if ((state == IDLE) && i_Start) begin
        cipher_key <= i_Key;
      end
      if (reach_last) begin
        cache_key   <= cipher_key;
        cache_last  <= key_d;
        cache_valid <= 1'b1;
      end
    end
  end
`else
  // No cache: every reverse start runs the precompute walk.
  always_comb begin
    cache_hit = 1'b0;
    hit_key   = '0;
  end
`endif

  // FSM state register.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic; starts are only honoured in IDLE.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (i_Start) begin
          if (i_fEncrypt || cache_hit) begin
            state_next = STREAM;
          end else begin
            state_next = PRECOMP;
          end
        end
      end
      PRECOMP: begin
        if (step_cnt == LAST_RND) begin
          state_next = STREAM;
        end
      end
      STREAM: begin
        if (i_Ready && at_last) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    o_Busy     = (state != IDLE);
    o_Valid    = (state == STREAM);
    o_Last     = at_last;
    o_RoundKey = out_key;
    o_RoundNum = out_num;
  end

  // Datapath next values for the key register and counters.
  always_comb begin
    key_d   = key_reg;
    round_d = round;
    step_d  = step_cnt;
    dir_d   = dir;
    unique case (state)
      IDLE: begin
        if (i_Start) begin
          key_d = i_Key;
          dir_d = i_fEncrypt;
          if (i_fEncrypt) begin
            round_d = '0;
          end else if (cache_hit) begin
            key_d   = hit_key;
            round_d = LAST_RND;
          end else begin
            step_d = 4'd1;
          end
        end
      end
      PRECOMP: begin
        key_d  = step_out;
        step_d = step_cnt + 4'd1;
        if (step_cnt == LAST_RND) begin
          round_d = LAST_RND;
        end
      end
      STREAM: begin
        if (i_Ready && !at_last) begin
          key_d   = step_out;
          round_d = dir ? (round + 4'd1) : (round - 4'd1);
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; the presented key/index is a separate copy so it
  // holds its last value while the working register walks during precompute.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      key_reg  <= '0;
      round    <= '0;
      step_cnt <= '0;
      dir      <= 1'b0;
      out_key  <= '0;
      out_num  <= '0;
    end else begin
      key_reg  <= key_d;
      round    <= round_d;
      step_cnt <= step_d;
      dir      <= dir_d;
      if (state_next == STREAM) begin
        out_key <= key_d;
        out_num <= round_d;
      end
    end
  end

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Testbench for key_schedule_ctrl: scoreboard of expected round keys from an
// independent AES-128 key-expansion model (S-box derived from GF(2^8) math).
module tb_key_schedule_ctrl;

  localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_B = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KEY_C = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] A_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] A_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

`ifdef LAST_KEY_CACHE_EN
  localparam int REPEAT_LAT = 1;
`else
  localparam int REPEAT_LAT = 11;
`endif

  logic         clk;
  logic         rst;
  logic         start;
  logic         encrypt;
  logic [127:0] key;
  logic         ready;
  logic         busy;
  logic         valid;
  logic [127:0] round_key;
  logic [3:0]   round_num;
  logic         last;

  typedef struct {
    logic [3:0]   num;
    logic [127:0] key;
    logic         last;
  } exp_t;

  exp_t         sbq[$];
  logic [127:0] rk [0:10];
  int           vectors;
  int           miscompares;

  key_schedule_ctrl #(.NUM_ROUNDS(10)) dut (
    .i_Clk      (clk),
    .i_Rst      (rst),
    .i_Start    (start),
    .i_fEncrypt (encrypt),
    .i_Key      (key),
    .i_Ready    (ready),
    .o_Busy     (busy),
    .o_Valid    (valid),
    .o_RoundKey (round_key),
    .o_RoundNum (round_num),
    .o_Last     (last)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_m(input logic [7:0] x);
    logic [7:0] inv, s;
    inv = '0;
    if (x != 8'h00) begin
      inv = x;
      for (int i = 0; i < 253; i++) inv = gmul(inv, x);
    end
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
        {inv[3:0], inv[7:4]} ^ 8'h63;
    return s;
  endfunction

  task automatic build_model(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i - 1];
      if (i % 4 == 0) begin
        t = {sbox_m(t[23:16]), sbox_m(t[15:8]), sbox_m(t[7:0]), sbox_m(t[31:24])} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i - 4] ^ t;
    end
    for (int r = 0; r <= 10; r++) rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; encrypt = 1'b0; key = '0; ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || valid !== 1'b0 || last !== 1'b0 || round_num !== 4'd0 || round_key !== '0) begin
      miscompares++;
      $display("FAIL reset_state: busy=%b valid=%b last=%b num=%0d key=%h, required all zero",
               busy, valid, last, round_num, round_key);
    end
  endtask

  task automatic test_forward(input logic [127:0] k, input logic [3:0] pat, input bit poke);
    exp_t         e;
    logic [127:0] held_key, k1, k10;
    logic [3:0]   held_num;
    bit           stalled;
    int           first;
    build_model(k);
    for (int r = 0; r <= 10; r++) begin
      e.num = 4'(r); e.key = rk[r]; e.last = (r == 10);
      sbq.push_back(e);
    end
    first = -1; stalled = 0; held_key = '0; held_num = '0; k1 = '0; k10 = '0;
    key = k; encrypt = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 200 && sbq.size() != 0; c++) begin
      ready = pat[c % 4];
      start = 1'b0;
      if (valid) begin
        if (first < 0) first = c;
        if (stalled) begin
          vectors++;
          if (round_key !== held_key || round_num !== held_num) begin
            miscompares++;
            $display("FAIL fwd_stall_hold: num=%0d key=%h, required num=%0d key=%h",
                     round_num, round_key, held_num, held_key);
          end
        end
        if (poke && (round_num == 4'd4 || last)) begin
          start = 1'b1; encrypt = 1'b0; key = ~k;
        end
        if (ready) begin
          e = sbq.pop_front();
          vectors++;
          if (round_key !== e.key || round_num !== e.num || last !== e.last) begin
            miscompares++;
            $display("FAIL fwd_key: num=%0d last=%b key=%h, required num=%0d last=%b key=%h",
                     round_num, last, round_key, e.num, e.last, e.key);
          end
          if (round_num == 4'd1) k1 = round_key;
          if (round_num == 4'd10) k10 = round_key;
        end
        stalled = !ready;
        held_key = round_key;
        held_num = round_num;
      end
      @(negedge clk);
    end
    start = 1'b0; ready = 1'b0;
    vectors++;
    if (sbq.size() != 0) begin
      miscompares++;
      $display("FAIL fwd_timeout: %0d keys outstanding, required 0", sbq.size());
      sbq.delete();
    end
    vectors++;
    if (first != 0) begin
      miscompares++;
      $display("FAIL fwd_latency: first valid at cycle %0d, required 1", first + 1);
    end
    vectors++;
    if (busy !== 1'b0 || valid !== 1'b0 || last !== 1'b0 || round_num !== 4'd10 || round_key !== rk[10]) begin
      miscompares++;
      $display("FAIL fwd_end_idle: busy=%b valid=%b last=%b num=%0d key=%h, required 0 0 0 10 %h",
               busy, valid, last, round_num, round_key, rk[10]);
    end
    if (k == KEY_A) begin
      vectors++;
      if (k1 !== A_RK1 || k10 !== A_RK10) begin
        miscompares++;
        $display("FAIL fwd_known_vector: rk1=%h rk10=%h, required %h %h", k1, k10, A_RK1, A_RK10);
      end
    end
  endtask

  task automatic test_reverse(input logic [127:0] k, input int exp_lat);
    exp_t         e;
    logic [127:0] held_key, k10;
    int           first;
    build_model(k);
    for (int r = 10; r >= 0; r--) begin
      e.num = 4'(r); e.key = rk[r]; e.last = (r == 0);
      sbq.push_back(e);
    end
    first = -1; held_key = round_key; k10 = '0;
    key = k; encrypt = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 200 && sbq.size() != 0; c++) begin
      ready = 1'b1;
      if (c == 0) begin
        vectors++;
        if (busy !== 1'b1 || (exp_lat > 1 && (valid !== 1'b0 || round_key !== held_key))) begin
          miscompares++;
          $display("FAIL rev_precomp_state: busy=%b valid=%b key=%h, required busy=1 held key %h",
                   busy, valid, round_key, held_key);
        end
      end
      if (valid) begin
        if (first < 0) first = c;
        e = sbq.pop_front();
        vectors++;
        if (round_key !== e.key || round_num !== e.num || last !== e.last) begin
          miscompares++;
          $display("FAIL rev_key: num=%0d last=%b key=%h, required num=%0d last=%b key=%h",
                   round_num, last, round_key, e.num, e.last, e.key);
        end
        if (round_num == 4'd10) k10 = round_key;
      end
      @(negedge clk);
    end
    ready = 1'b0;
    vectors++;
    if (sbq.size() != 0) begin
      miscompares++;
      $display("FAIL rev_timeout: %0d keys outstanding, required 0", sbq.size());
      sbq.delete();
    end
    vectors++;
    if (first + 1 != exp_lat) begin
      miscompares++;
      $display("FAIL rev_latency: first valid at cycle %0d, required %0d", first + 1, exp_lat);
    end
    vectors++;
    if (busy !== 1'b0 || valid !== 1'b0 || last !== 1'b0 || round_num !== 4'd0 || round_key !== k) begin
      miscompares++;
      $display("FAIL rev_end_idle: busy=%b valid=%b last=%b num=%0d key=%h, required 0 0 0 0 %h",
               busy, valid, last, round_num, round_key, k);
    end
    if (k == KEY_A) begin
      vectors++;
      if (k10 !== A_RK10) begin
        miscompares++;
        $display("FAIL rev_known_vector: rk10=%h, required %h", k10, A_RK10);
      end
    end
  endtask

  task automatic test_reset_mid(input logic [127:0] k);
    key = k; encrypt = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    vectors++;
    if (busy !== 1'b1 || valid !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_precomp: busy=%b valid=%b, required busy=1 valid=0", busy, valid);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (busy !== 1'b0 || valid !== 1'b0 || last !== 1'b0 || round_num !== 4'd0 || round_key !== '0) begin
      miscompares++;
      $display("FAIL async_reset: busy=%b valid=%b last=%b num=%0d key=%h, required all zero",
               busy, valid, last, round_num, round_key);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_idle: busy=%b valid=%b, required 0 0", busy, valid);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1; start = 1'b0; encrypt = 1'b0; key = '0; ready = 1'b0;
    test_reset();
    test_reverse(KEY_A, 11);
    test_forward(KEY_A, 4'b1111, 1'b0);
    test_forward(KEY_A, 4'b1001, 1'b0);
    test_forward(KEY_C, 4'b1111, 1'b1);
    test_reset_mid(KEY_A);
    test_forward(KEY_B, 4'b1111, 1'b0);
    test_reverse(KEY_B, REPEAT_LAT);
    test_reverse(KEY_C, 11);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/key_schedule_ctrl.md
KEY_SCHEDULE_CTRL -- requirements
Module: key_schedule_ctrl

Interface
REQ-001 The block SHALL provide parameter NUM_ROUNDS, default 10, giving the number of round keys after the cipher key; legal range 1..10.
REQ-002 The block SHALL have port i_Clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port i_Rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port i_Start, input, 1 bit: request to begin a key stream.
REQ-005 The block SHALL have port i_fEncrypt, input, 1 bit: 1 selects forward order (round 0 up to NUM_ROUNDS), 0 selects reverse order (round NUM_ROUNDS down to 0); sampled with i_Start.
REQ-006 The block SHALL have port i_Key, input, 128 bits: cipher key (round-0 key); sampled with i_Start.
REQ-007 The block SHALL have port i_Ready, input, 1 bit: consumer accepts o_RoundKey.
REQ-008 The block SHALL have port o_Busy, output, 1 bit: high while not IDLE.
REQ-009 The block SHALL have port o_Valid, output, 1 bit: o_RoundKey is presented.
REQ-010 The block SHALL have port o_RoundKey, output, 128 bits: current round key.
REQ-011 The block SHALL have port o_RoundNum, output, 4 bits: index of o_RoundKey.
REQ-012 The block SHALL have port o_Last, output, 1 bit: high with the final key of the stream.

Function
REQ-013 The block SHALL instantiate exactly one combinational key-expansion step and hold one 128-bit key register; its round input is the higher index of the key pair being bridged (1..NUM_ROUNDS); its direction input is 1 for forward steps and 0 for inverse steps.
REQ-014 The FSM SHALL have states IDLE, PRECOMP, STREAM; i_Start SHALL be accepted only in IDLE and ignored elsewhere.
REQ-015 On an accepted start with i_fEncrypt=1: key register <= i_Key, round <= 0, next state STREAM.
REQ-016 On an accepted start with i_fEncrypt=0: key register <= i_Key, step counter <= 1, next state PRECOMP.
REQ-017 In PRECOMP, each cycle SHALL apply one forward step with round = step counter; after step NUM_ROUNDS the next state SHALL be STREAM with round = NUM_ROUNDS; decrypt first-key latency = NUM_ROUNDS+1 cycles from start.
REQ-018 In STREAM, o_Valid=1; o_RoundKey and o_RoundNum SHALL stay stable while o_Valid && !i_Ready.
REQ-019 On each handshake (o_Valid && i_Ready) that is not the last, the key register SHALL advance one step (forward: round+1; reverse: inverse step, round-1) in the same edge; throughput one key per cycle.
REQ-020 o_Last SHALL be high exactly when o_RoundNum equals NUM_ROUNDS (forward) or 0 (reverse) in STREAM; its handshake SHALL return the FSM to IDLE, with o_Valid low the next cycle.
REQ-021 i_Start asserted on the final-handshake cycle SHALL be ignored (FSM not yet IDLE).
REQ-022 o_Valid and o_Last SHALL be 0 outside STREAM; o_RoundKey/o_RoundNum SHALL hold their last value outside STREAM.

Reset
REQ-023 i_Rst high SHALL immediately force state IDLE and o_Busy, o_Valid, o_Last, o_RoundNum, o_RoundKey, key register and counters to 0, aborting any stream or precompute.
REQ-024 After i_Rst deasserts, the first accepted i_Start SHALL behave as from power-up, with any cache invalid.

Configuration
REQ-025 With macro LAST_KEY_CACHE_EN defined, the block SHALL store the cipher key and round-NUM_ROUNDS key, plus a valid bit, whenever round NUM_ROUNDS is reached (forward STREAM or PRECOMP end).
REQ-026 With LAST_KEY_CACHE_EN defined, a reverse start whose i_Key equals the cached cipher key with valid set SHALL skip PRECOMP and enter STREAM next cycle, key register loaded from cache.
REQ-027 Without LAST_KEY_CACHE_EN, no cache storage SHALL exist and every reverse start SHALL run PRECOMP.

Verification
REQ-028 Forward, i_Key=2b7e151628aed2a6abf7158809cf4f3c, i_Ready=1 -> keys rounds 0..10 on consecutive cycles, round 1 = a0fafe1788542cb123a339392a6c7605, round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 with o_Last.
REQ-029 Reverse, same key, i_Ready=1 -> o_Valid first high 11 cycles after start with round 10 = d014f9a8...0ca6, then rounds 9..0, round 0 = 2b7e1516...4f3c with o_Last.
REQ-030 Forward with i_Ready toggling 1,0,0,1 -> each key held unchanged across stalls, no key skipped or repeated.
REQ-031 i_Start pulsed at stream round 4, and on the last-handshake cycle -> both ignored; stream completes normally.
REQ-032 i_Rst pulsed mid-PRECOMP -> all outputs 0 immediately; a new forward start afterwards yields correct round 1.
REQ-033 LAST_KEY_CACHE_EN: forward run then reverse start with same key -> round 10 valid 1 cycle after start; different key -> 11 cycles.
